// File: rtl/sh_cluster_port.sv
// rtl/sh_cluster_port.sv - super-hub endpoint of one cluster-hub link: credited upstream FIFO, credit-gated downstream register.
// Optional flit statistics counters: SH_PORT_STATS_EN.
module sh_cluster_port #(
    parameter int FLIT_W     = 20,
    parameter int UP_DEPTH   = 4,
    parameter int DN_CREDITS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FLIT_W-1:0]                 link_up_data,
    input  logic                              link_up_valid,
    output logic                              link_up_co,
    output logic [FLIT_W-1:0]                 link_dn_data,
    output logic                              link_dn_valid,
    input  logic                              link_dn_ci,
    output logic [FLIT_W-1:0]                 sw_up_data,
    output logic                              sw_up_valid,
    input  logic                              sw_up_ready,
    input  logic [FLIT_W-1:0]                 sw_dn_data,
    input  logic                              sw_dn_valid,
    output logic                              sw_dn_ready,
    output logic [$clog2(DN_CREDITS+1)-1:0]   dn_credits,
    output logic                              up_overflow,
    output logic                              credit_err,
    output logic [15:0]                       up_flit_cnt,
    output logic [15:0]                       dn_flit_cnt
);
    localparam int AW = $clog2(UP_DEPTH);
    localparam int CW = $clog2(DN_CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(DN_CREDITS);

    logic [FLIT_W-1:0] mem [UP_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              send;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign sw_up_valid = !empty;
    assign sw_up_data  = mem[rd_ptr[AW-1:0]];
    assign pop         = !empty && sw_up_ready;
    // A pop frees the head slot at the same edge, so a full FIFO can still take a write.
    assign push        = link_up_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= link_up_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            link_up_co  <= 1'b0;
            up_overflow <= 1'b0;
        end else begin
            link_up_co <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (link_up_valid && !push) begin
                up_overflow <= 1'b1;
            end
        end
    end

    assign sw_dn_ready = (dn_credits != '0);
    assign send        = sw_dn_valid && sw_dn_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            link_dn_valid <= 1'b0;
            link_dn_data  <= '0;
            dn_credits    <= CRED_MAX;
            credit_err    <= 1'b0;
        end else begin
            link_dn_valid <= send;
            if (send) begin
                link_dn_data <= sw_dn_data;
            end
            case ({send, link_dn_ci})
                2'b10: dn_credits <= dn_credits - 1'b1;
                2'b01: begin
                    if (dn_credits == CRED_MAX) begin
                        credit_err <= 1'b1;
                    end else begin
                        dn_credits <= dn_credits + 1'b1;
                    end
                end
                default: dn_credits <= dn_credits;
            endcase
        end
    end

`ifdef SH_PORT_STATS_EN
    logic [15:0] up_cnt;
    logic [15:0] dn_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_cnt <= '0;
            dn_cnt <= '0;
        end else begin
            if (pop) begin
                up_cnt <= up_cnt + 16'd1;
            end
            if (send) begin
                dn_cnt <= dn_cnt + 16'd1;
            end
        end
    end

    assign up_flit_cnt = up_cnt;
    assign dn_flit_cnt = dn_cnt;
`else
    assign up_flit_cnt = 16'd0;
    assign dn_flit_cnt = 16'd0;
`endif

endmodule

// File: doc/sh_cluster_port.md
Name: sh_cluster_port

Overview:
- Super-hub side endpoint of one cluster-hub ↔ super-hub link. It is the far end of the hub's up_to_SH / down_from_SH channels.
- Upstream path: accepts 20-bit flits from the cluster hub into a local FIFO, presents them to the super-hub switch, and returns one credit per slot freed.
- Downstream path: accepts flits from the super-hub switch and transmits them to the hub, gated by a credit counter replenished by the hub's credit pulses.
- One instance per cluster (four per super-hub).

Parameters:
- FLIT_W, 20, flit width; [19:18] dest cluster, [17:16] dest local, [15:0] payload.
- UP_DEPTH, 4, upstream FIFO depth; power of two, at least 2. Also the credit count the hub is built with.
- DN_CREDITS, 4, initial and maximum downstream credits; equals the hub's downstream buffer depth.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- link_up_data  in  FLIT_W  flit from cluster hub
- link_up_valid  in  1  one-cycle strobe per flit
- link_up_co  out  1  credit pulse to hub, one per freed upstream slot
- link_dn_data  out  FLIT_W  flit to cluster hub
- link_dn_valid  out  1  one-cycle strobe per flit
- link_dn_ci  in  1  credit pulse from hub
- sw_up_data  out  FLIT_W  head of upstream FIFO
- sw_up_valid  out  1  FIFO non-empty
- sw_up_ready  in  1  switch accepts head
- sw_dn_data  in  FLIT_W  flit from switch
- sw_dn_valid  in  1  switch offers flit
- sw_dn_ready  out  1  port can send (credits available)
- dn_credits  out  $clog2(DN_CREDITS+1)  current credit count
- up_overflow  out  1  sticky: flit arrived while FIFO full
- credit_err  out  1  sticky: credit received at max count
- up_flit_cnt  out  16  upstream flits popped (see optional feature)
- dn_flit_cnt  out  16  downstream flits sent (see optional feature)

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, rd/wr pointers 0, link_up_co=0, link_dn_valid=0, link_dn_data=0, dn_credits=DN_CREDITS, up_overflow=0, credit_err=0, counters 0.
- Upstream write: link_up_valid=1 writes link_up_data at the rising edge.
  - sw_up_valid rises the next cycle (1-cycle latency); sw_up_data comes directly from the FIFO head register.
- Upstream pop: on sw_up_valid & sw_up_ready.
  - link_up_co=1 for exactly the next cycle, registered; one pulse per pop.
  - Back-to-back pops give back-to-back pulses.
- Simultaneous write and pop:
  - Non-empty FIFO: both occur, occupancy unchanged.
  - Empty FIFO: no pop; the written flit appears next cycle.
  - Full FIFO with pop: the write succeeds.
- Full FIFO, write, no pop: flit dropped, up_overflow set (sticky until reset), FIFO contents unchanged.
- Pointers are log2(UP_DEPTH)+1 bits; the extra MSB distinguishes full from empty; wrap-around is natural.
- Downstream: sw_dn_ready = (dn_credits != 0), combinational from the register.
  - On sw_dn_valid & sw_dn_ready: link_dn_data <= sw_dn_data and link_dn_valid=1 for the next cycle only.
  - Throughput is one flit per cycle while credits last.
- Credit update each cycle: send & !ci → -1; ci & !send → +1; both → unchanged; neither → unchanged.
  - Never underflows, because a send requires a credit.
- ci & !send with dn_credits==DN_CREDITS: count stays at max, credit_err set (sticky).
- No header rewriting; flits pass bit-exact in both directions. Order is preserved (FIFO downstream of hub, single register upstream of hub).

Optional Feature:
- Macro SH_PORT_STATS_EN.
- Defined: up_flit_cnt increments on every upstream pop; dn_flit_cnt increments on every downstream send. Both 16-bit, wrap 0xFFFF→0, reset to 0.
- Undefined: both ports driven constant 0 and no counter flops are instantiated. All other behaviour is identical.

Test Plan:
- Reset with sw_up_ready=0; inject 4 flits 0x1_0001..0x1_0004 on consecutive cycles → sw_up_valid=1 from cycle after first, no link_up_co. A 5th flit 0xF_FFFF → up_overflow=1, FIFO still holds the 4. Then ready=1 → pops 0x10001..0x10004 in order, 4 consecutive link_up_co pulses, 1 cycle after each pop.
- Empty FIFO, link_up_valid and sw_up_ready both high on the same cycle with 0x2_ABCD → no pop that cycle; 0x2ABCD popped next cycle; exactly one link_up_co.
- sw_dn_valid held with flits 0xA_0000..0xA_0005, no link_dn_ci → exactly 4 link_dn_valid pulses carrying 0xA0000..0xA0003, dn_credits 4→0, sw_dn_ready=0. One ci pulse → 0xA0004 sent next, credits return to 0.
- Credits=2, send and ci in the same cycle → dn_credits stays 2. Credits=4, ci pulse → dn_credits=4, credit_err=1.
- Assert rst low mid-stream with 2 flits buffered and credits=1 → all outputs at reset values immediately (asynchronous), dn_credits=4, FIFO empty, sticky flags cleared.
- With SH_PORT_STATS_EN: 65537 upstream pops → up_flit_cnt=1. Without the macro → both counters read 0 throughout.
